// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: command sequencer in front of a small EEPROM array.
// Writes expand to erase then program; every erase/write is read back.
module eeprom_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int ERASE_CYCLES = 4,
  parameter int PROG_CYCLES = 4,
  parameter logic [DATA_W-1:0] ERASED_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_erase,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ERASE,
    S_PROG,
    S_VERIFY,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_ER = 2'b10;
  localparam logic [1:0] OP_IL = 2'b11;
  localparam logic [7:0] LP_ER = 8'(ERASE_CYCLES - 1);
  localparam logic [7:0] LP_PG = 8'(PROG_CYCLES - 1);

  state_t r_state;
  state_t w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt;
  logic [1:0] r_op;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic r_mem_we;
  logic r_mem_erase;
  logic [DATA_W-1:0] r_mem_wdata;
  logic r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic r_rsp_err;
  logic w_accept;
  logic [DATA_W-1:0] w_expect;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_expect = (r_op == OP_WR) ? r_wdata : ERASED_VAL;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_erase = r_mem_erase;
  assign mem_wdata = r_mem_wdata;

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            (req_op == OP_RD): w_next = S_READ;
            (req_op == OP_WR),
            (req_op == OP_ER): begin
              w_next = S_ERASE;
              w_cnt  = LP_ER;
            end
            default: w_next = S_RESP;
          endcase
        end
      end
      S_READ: w_next = S_RESP;
      S_ERASE: begin
        if (r_cnt == 8'd0) begin
          if (r_op == OP_WR) begin
            w_next = S_PROG;
            w_cnt  = LP_PG;
          end else begin
            w_next = S_VERIFY;
          end
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_PROG: begin
        if (r_cnt == 8'd0) w_next = S_VERIFY;
        else w_cnt = r_cnt - 8'd1;
      end
      S_VERIFY: w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_RD;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_erase <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_mem_erase <= (w_next == S_ERASE);
      r_mem_we    <= (w_next == S_PROG);
      r_mem_wdata <= (w_next == S_PROG) ? r_wdata : '0;
      r_rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        r_op    <= req_op;
        r_wdata <= req_wdata;
        if (req_op != OP_IL) begin
          r_mem_addr <= req_addr;
        end else begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
        end
      end
      if (r_state == S_READ) begin
        r_rsp_rdata <= mem_rdata;
        r_rsp_err   <= 1'b0;
      end
      if (r_state == S_VERIFY) begin
        r_rsp_rdata <= mem_rdata;
        r_rsp_err   <= (mem_rdata != w_expect);
      end
    end
  end

endmodule
